// File: rtl/sample_serializer.sv
// sample_serializer: mono sample to I2S-style serial stream (bclk/lrck/sdata) with
// per-frame sample request handshake and a sticky underrun flag.
module sample_serializer #(
  parameter int CLK_DIV     = 4,
  parameter int SAMPLE_BITS = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   play_enable,
  input  logic [SAMPLE_BITS-1:0] sample_out,
  input  logic                   sample_ready,
  output logic                   generate_next_sample,
  input  logic                   underrun_clr,
  output logic                   bclk,
  output logic                   lrck,
  output logic                   sdata,
  output logic                   underrun
);
  localparam int BW = $clog2(2 * SAMPLE_BITS);
  localparam logic [BW-1:0] LAST = BW'(2 * SAMPLE_BITS - 1);
  localparam logic [BW-1:0] HALF = BW'(SAMPLE_BITS);
  localparam logic [7:0] DLAST = 8'(CLK_DIV - 1);
  typedef enum logic {IDLE, RUN} state_t;
  state_t                 state_q;
  logic [7:0]             div_q;
  logic [BW-1:0]          bit_q, bit_d, slot_d;
  logic [SAMPLE_BITS-1:0] hold_q, frame_q, src_d;
  logic bclk_q, lrck_q, sdata_q, gen_q, und_q, fresh_q, first_q, fall_d, start_d;
  // first_q marks the first falling edge after entering RUN, which is always bit 0
  always_comb begin
    fall_d  = state_q == RUN && play_enable && div_q == DLAST && bclk_q;
    bit_d   = (first_q || bit_q == LAST) ? '0 : bit_q + 1'b1;
    start_d = fall_d && bit_d == '0;
    slot_d  = bit_d >= HALF ? bit_d - HALF : bit_d;
    src_d   = (start_d ? hold_q : frame_q) << slot_d;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      hold_q  <= '0;
      frame_q <= '0;
      bclk_q  <= 1'b0;
      lrck_q  <= 1'b0;
      sdata_q <= 1'b0;
      gen_q   <= 1'b0;
      und_q   <= 1'b0;
      fresh_q <= 1'b0;
      first_q <= 1'b1;
    end else begin
      if (sample_ready) hold_q <= sample_out;
      fresh_q <= sample_ready || (fresh_q && !start_d);
      und_q   <= (start_d && !fresh_q) || (und_q && !underrun_clr);
      gen_q   <= start_d;
      if (state_q == IDLE || !play_enable) begin
        state_q <= play_enable ? RUN : IDLE;
        div_q   <= '0;
        bit_q   <= '0;
        bclk_q  <= 1'b0;
        lrck_q  <= 1'b0;
        sdata_q <= 1'b0;
        first_q <= 1'b1;
      end else begin
        div_q <= div_q == DLAST ? '0 : div_q + 8'd1;
        if (div_q == DLAST) bclk_q <= !bclk_q;
        if (fall_d) begin
          bit_q   <= bit_d;
          first_q <= 1'b0;
          lrck_q  <= bit_d >= HALF;
          sdata_q <= src_d[SAMPLE_BITS-1];
        end
        if (start_d) frame_q <= hold_q;
      end
    end
  end
  assign generate_next_sample = gen_q;
  assign bclk     = bclk_q;
  assign lrck     = lrck_q;
  assign sdata    = sdata_q;
  assign underrun = und_q;
endmodule

// File: tb/tb_sample_serializer.sv
// tb_sample_serializer: DAC-side decoder plus sample/underrun reference model.
module tb_sample_serializer;
  localparam int CD = 4, SB = 16;
  logic clk = 0, reset_n = 0, play_enable = 0, sample_ready = 0, underrun_clr = 0;
  logic [SB-1:0] sample_out = '0;
  logic generate_next_sample, bclk, lrck, sdata, underrun;
  int checks = 0, failures = 0;

  sample_serializer #(.CLK_DIV(CD), .SAMPLE_BITS(SB)) dut (
    .clk(clk), .reset_n(reset_n), .play_enable(play_enable), .sample_out(sample_out),
    .sample_ready(sample_ready), .generate_next_sample(generate_next_sample),
    .underrun_clr(underrun_clr), .bclk(bclk), .lrck(lrck), .sdata(sdata), .underrun(underrun));

  always #5 clk = ~clk;

  logic [15:0] m_hold = '0, cur_exp = '0, resp_val = '0;
  bit m_fresh = 0, m_und = 0, prev_bclk = 0, resp_rand = 0, rand_delay = 0;
  int bcnt = -1, n_gen = 0, since_rise = 0, last_period = 0, since_gen = 0, last_gap = 0, resp_cnt = 0;
  logic [31:0] gbits = '0, glr = '0;
  logic [31:0] got_q[$], lr_q[$];
  logic [15:0] exp_q[$], resp_q[$];

  task automatic tick();
    logic rdy, clr, pe, set;
    logic [15:0] sv;
    rdy = sample_ready; clr = underrun_clr; pe = play_enable; sv = sample_out; set = 0;
    @(posedge clk); #1;
    since_rise++; since_gen++;
    if (reset_n) begin
      if (generate_next_sample) begin
        if (bcnt == 32) begin got_q.push_back(gbits); lr_q.push_back(glr); exp_q.push_back(cur_exp); end
        cur_exp = m_hold; set = !m_fresh; m_fresh = 0;
        bcnt = 0; gbits = '0; glr = '0; n_gen++; last_gap = since_gen; since_gen = 0;
      end
      if (rdy) begin m_hold = sv; m_fresh = 1; end
      m_und = set ? 1'b1 : clr ? 1'b0 : m_und;
      if (!pe) bcnt = -1;
      if (bclk && !prev_bclk) begin
        last_period = since_rise; since_rise = 0;
        if (bcnt >= 0 && bcnt < 32) begin gbits = {gbits[30:0], sdata}; glr = {glr[30:0], lrck}; bcnt++; end
      end
    end
    prev_bclk = bclk;
    sample_ready = 0; underrun_clr = 0;
    if (resp_cnt > 0) begin
      resp_cnt--;
      if (resp_cnt == 0) begin sample_ready = 1; sample_out = resp_val; end
    end
    if (reset_n && generate_next_sample) begin
      if (resp_q.size() > 0) begin resp_val = resp_q.pop_front(); resp_cnt = 3; end
      else if (resp_rand) begin resp_val = 16'($urandom); resp_cnt = rand_delay ? $urandom_range(1, 300) : 3; end
    end
  endtask

  task automatic wait_gens(input int n);
    int target, b;
    target = n_gen + n; b = 0;
    while (n_gen < target && b < n * 400) begin tick(); b++; end
    checks++;
    if (n_gen < target) begin failures++; $display("FAIL wait_gens: got %0d frame starts, need %0d", n_gen, target); end
  endtask

  task automatic clear_frames();
    got_q.delete(); lr_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset();
    reset_n = 0; play_enable = 1; sample_ready = 1; sample_out = 16'hBEEF;
    repeat (3) tick();
    checks++;
    if ({bclk, lrck, sdata, generate_next_sample, underrun} !== 5'b0) begin
      failures++; $display("FAIL reset_outputs: got %b want 00000", {bclk, lrck, sdata, generate_next_sample, underrun});
    end
    play_enable = 0; sample_ready = 0; reset_n = 1;
    tick(); tick();
    checks++;
    if ({bclk, lrck, sdata, generate_next_sample, underrun} !== 5'b0) begin
      failures++; $display("FAIL reset_idle: got %b want 00000", {bclk, lrck, sdata, generate_next_sample, underrun});
    end
  endtask

  task automatic test_fixed_1234();
    repeat (4) resp_q.push_back(16'h1234);
    clear_frames(); play_enable = 1;
    wait_gens(4);
    checks++;
    if (got_q[0] !== 32'h0) begin failures++; $display("FAIL fixed_first: got %h want 00000000", got_q[0]); end
    for (int i = 1; i < 3; i++) begin
      checks++;
      if (got_q[i] !== 32'h12341234 || lr_q[i] !== 32'h0000FFFF) begin
        failures++; $display("FAIL fixed_frame%0d: got %h lr %h want 12341234 lr 0000ffff", i, got_q[i], lr_q[i]);
      end
    end
    checks++;
    if (last_period != 2 * CD) begin failures++; $display("FAIL bclk_period: got %0d want %0d", last_period, 2 * CD); end
    checks++;
    if (last_gap != 4 * CD * SB) begin failures++; $display("FAIL frame_len: got %0d want %0d", last_gap, 4 * CD * SB); end
    checks++;
    if (underrun !== 1'b1 || m_und !== 1'b1) begin failures++; $display("FAIL first_underrun: got %b want 1", underrun); end
    underrun_clr = 1; tick();
    checks++;
    if (underrun !== 1'b0) begin failures++; $display("FAIL underrun_clr: got %b want 0", underrun); end
  endtask

  task automatic test_alternate();
    resp_rand = 1; resp_q.push_back(16'h8001); resp_q.push_back(16'h7FFE);
    clear_frames();
    wait_gens(4);
    checks++;
    if (got_q[2] !== 32'h80018001) begin failures++; $display("FAIL alt_8001: got %h want 80018001", got_q[2]); end
    checks++;
    if (got_q[3] !== 32'h7FFE7FFE) begin failures++; $display("FAIL alt_7ffe: got %h want 7ffe7ffe", got_q[3]); end
    checks++;
    if (underrun !== 1'b0) begin failures++; $display("FAIL alt_underrun: got %b want 0", underrun); end
  endtask

  task automatic test_underrun();
    resp_rand = 0; resp_q.push_back(16'h00FF);
    wait_gens(2);
    checks++;
    if (underrun !== 1'b0) begin failures++; $display("FAIL und_before: got %b want 0", underrun); end
    resp_rand = 1;
    wait_gens(1);
    checks++;
    if (underrun !== 1'b1) begin failures++; $display("FAIL und_set: got %b want 1", underrun); end
    wait_gens(1);
    checks++;
    if (got_q[$-1] !== 32'h00FF00FF || got_q[$] !== 32'h00FF00FF) begin
      failures++; $display("FAIL und_replay: got %h %h want 00ff00ff x2", got_q[$-1], got_q[$]);
    end
    underrun_clr = 1; tick();
    checks++;
    if (underrun !== 1'b0) begin failures++; $display("FAIL und_clr: got %b want 0", underrun); end
  endtask

  task automatic test_same_cycle();
    logic [15:0] x;
    x = 16'($urandom);
    resp_rand = 0; resp_q.push_back(x);
    wait_gens(1);
    repeat (4 * CD * SB - 1) tick();
    sample_ready = 1; sample_out = 16'hAAAA;
    tick();
    checks++;
    if (generate_next_sample !== 1'b1) begin failures++; $display("FAIL same_cycle_start: got %b want 1", generate_next_sample); end
    resp_rand = 1;
    wait_gens(2);
    checks++;
    if (got_q[$-1] !== {x, x} || got_q[$] !== 32'hAAAAAAAA) begin
      failures++; $display("FAIL same_cycle_frames: got %h %h want %h aaaaaaaa", got_q[$-1], got_q[$], {x, x});
    end
    checks++;
    if (underrun !== 1'b0) begin failures++; $display("FAIL same_cycle_underrun: got %b want 0", underrun); end
  endtask

  task automatic test_abort();
    logic [15:0] b;
    int n;
    bit seen;
    b = 16'($urandom) | 16'h8000;
    wait_gens(1);
    n = 0;
    while (bcnt != 20 && n < 400) begin tick(); n++; end
    play_enable = 0; tick();
    checks++;
    if ({bclk, lrck, sdata, generate_next_sample} !== 4'b0) begin
      failures++; $display("FAIL abort_idle: got %b want 0000", {bclk, lrck, sdata, generate_next_sample});
    end
    sample_ready = 1; sample_out = b;
    seen = 0;
    repeat (6) begin tick(); seen |= generate_next_sample; end
    checks++;
    if (seen) begin failures++; $display("FAIL idle_request: got 1 want 0"); end
    play_enable = 1; n = 0;
    do begin tick(); n++; end while (!generate_next_sample && n < 50);
    checks++;
    if (n != 2 * CD + 1 || lrck !== 1'b0 || sdata !== b[15]) begin
      failures++; $display("FAIL reentry: got %0d clk lrck %b sdata %b want %0d clk lrck 0 sdata %b", n, lrck, sdata, 2 * CD + 1, b[15]);
    end
    wait_gens(1);
    checks++;
    if (got_q[$] !== {b, b} || underrun !== 1'b0) begin
      failures++; $display("FAIL reentry_frame: got %h und %b want %h und 0", got_q[$], underrun, {b, b});
    end
  endtask

  task automatic test_async_reset();
    int n;
    wait_gens(1);
    n = 0;
    while (bcnt != 10 && n < 400) begin tick(); n++; end
    #2 reset_n = 0;
    #1;
    checks++;
    if ({bclk, lrck, sdata, generate_next_sample, underrun} !== 5'b0) begin
      failures++; $display("FAIL async_reset: got %b want 00000", {bclk, lrck, sdata, generate_next_sample, underrun});
    end
    m_hold = '0; m_fresh = 0; m_und = 0; bcnt = -1; resp_cnt = 0; sample_ready = 0;
    tick(); tick();
    reset_n = 1; tick();
    checks++;
    if (underrun !== 1'b0) begin failures++; $display("FAIL post_reset_underrun: got %b want 0", underrun); end
    clear_frames();
    wait_gens(2);
    checks++;
    if (got_q[$] !== 32'h0 || lr_q[$] !== 32'h0000FFFF) begin
      failures++; $display("FAIL post_reset_frame: got %h lr %h want 00000000 lr 0000ffff", got_q[$], lr_q[$]);
    end
  endtask

  task automatic test_random();
    rand_delay = 1; resp_rand = 1;
    clear_frames();
    for (int i = 0; i < 10; i++) begin
      if ($urandom_range(0, 2) == 0) underrun_clr = 1;
      wait_gens(1);
    end
    for (int i = 0; i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== {exp_q[i], exp_q[i]} || lr_q[i] !== 32'h0000FFFF) begin
        failures++; $display("FAIL random_frame%0d: got %h lr %h want %h lr 0000ffff", i, got_q[i], lr_q[i], {exp_q[i], exp_q[i]});
      end
    end
    checks++;
    if (underrun !== m_und) begin failures++; $display("FAIL random_underrun: got %b want %b", underrun, m_und); end
  endtask

  initial begin
    test_reset();
    test_fixed_1234();
    test_alternate();
    test_underrun();
    test_same_cycle();
    test_abort();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
